// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: per-channel synchronise, debounce, edge-select and fixed-width pulse generator
module multi_pulse_gen #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 0,
  parameter int PULSE_W     = 1,
  parameter int RETRIGGER   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH-1:0]     in,
  input  logic              en,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     miss_clr,
  output logic [CH-1:0]     out,
  output logic [CH-1:0]     miss
);
  localparam int PW_W = $clog2(PULSE_W + 1);
  localparam logic [PW_W-1:0] LOAD = PW_W'(PULSE_W - 1);
  localparam bit RT = RETRIGGER != 0;
  typedef enum logic {IDLE, ACTIVE} state_t;
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sh;
    logic stable, stable_d, rise, fall, ev, pulse, miss_q, miss_nx;
    logic [1:0] m;
    state_t state, state_nx;
    logic [PW_W-1:0] cnt, cnt_nx;
    // synchroniser shift chain, last stage is the synchronised level
    always_ff @(posedge clk) sh <= reset ? '0 : {sh[SYNC_STAGES-2:0], in[i]};
    if (DB_CYCLES > 0) begin : g_db
      localparam int DW = $clog2(DB_CYCLES + 1);
      logic [DW-1:0] dcnt;
      logic st;
      // accept a new level only after it persists DB_CYCLES consecutive cycles
      always_ff @(posedge clk)
        if (reset) begin
          st   <= 1'b0;
          dcnt <= '0;
        end else if (sh[SYNC_STAGES-1] == st) dcnt <= '0;
        else if (dcnt == DW'(DB_CYCLES - 1)) begin
          st   <= sh[SYNC_STAGES-1];
          dcnt <= '0;
        end else dcnt <= dcnt + 1'b1;
      assign stable = st;
    end else begin : g_nodb
      assign stable = sh[SYNC_STAGES-1];
    end
    // delayed stable level for edge detection
    always_ff @(posedge clk) stable_d <= reset ? 1'b0 : stable;
    assign m    = mode[2*i +: 2];
    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign ev   = en & (m == 2'b00 ? rise : m == 2'b01 ? fall : m == 2'b10 ? (rise | fall) : 1'b0);
    // pulse state, width counter and sticky miss registers
    always_ff @(posedge clk)
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        miss_q <= 1'b0;
      end else begin
        state  <= state_nx;
        cnt    <= cnt_nx;
        miss_q <= miss_nx;
      end
    // next state: retrigger reloads the width, otherwise an active-pulse event is a miss
    always_comb begin
      state_nx = state == IDLE ? (ev ? ACTIVE : IDLE) : (cnt == '0 && !(ev && RT)) ? IDLE : ACTIVE;
      cnt_nx   = state == IDLE ? (ev ? LOAD : '0) : (ev && RT) ? LOAD : cnt == '0 ? '0 : cnt - 1'b1;
      miss_nx  = (state == ACTIVE && ev && !RT) | (miss_q & ~miss_clr[i]);
    end
    // output decode
    always_comb pulse = state == ACTIVE;
    assign out[i]  = pulse;
    assign miss[i] = miss_q;
  end
endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: directed checks of multi_pulse_gen across several parameter sets
module tb_multi_pulse_gen;
  logic clk, reset, en;
  logic [3:0] in, miss_clr;
  logic [7:0] mode;
  logic [3:0] out_a, out_b, out_c, out_d, out_e;
  logic [3:0] miss_a, miss_b, miss_c, miss_d, miss_e;
  int n_cmp, n_err;

  multi_pulse_gen u_a (.clk(clk), .reset(reset), .in(in), .en(en), .mode(mode), .miss_clr(miss_clr), .out(out_a), .miss(miss_a));
  multi_pulse_gen #(.DB_CYCLES(4)) u_b (.clk(clk), .reset(reset), .in(in), .en(en), .mode(mode), .miss_clr(miss_clr), .out(out_b), .miss(miss_b));
  multi_pulse_gen #(.PULSE_W(3)) u_c (.clk(clk), .reset(reset), .in(in), .en(en), .mode(mode), .miss_clr(miss_clr), .out(out_c), .miss(miss_c));
  multi_pulse_gen #(.PULSE_W(4)) u_d (.clk(clk), .reset(reset), .in(in), .en(en), .mode(mode), .miss_clr(miss_clr), .out(out_d), .miss(miss_d));
  multi_pulse_gen #(.PULSE_W(4), .RETRIGGER(1)) u_e (.clk(clk), .reset(reset), .in(in), .en(en), .mode(mode), .miss_clr(miss_clr), .out(out_e), .miss(miss_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in = '0;
    en = 1'b1;
    mode = '0;
    miss_clr = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    in = '0;
    en = 1'b1;
    mode = '0;
    miss_clr = '0;
    do_reset();
    check("rst_out", {out_a, out_b, out_c, out_d, out_e}, 0);
    check("rst_miss", {miss_a, miss_b, miss_c, miss_d, miss_e}, 0);

    // basic latency and single-cycle width
    in[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("t1_e%0d", e), out_a, e == 3 ? 4'b0001 : 4'b0000);
    end

    // debounce: short glitch rejected, long level accepted
    do_reset();
    in[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("t2_glitch_e%0d", e), out_b, 4'b0000);
      if (e == 3) in[1] = 1'b0;
    end
    in[1] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check($sformatf("t2_long_e%0d", e), out_b, e == 7 ? 4'b0010 : 4'b0000);
      if (e == 6) in[1] = 1'b0;
    end

    // both-edge mode and disabled channel
    do_reset();
    mode = 8'b0010_0000;
    in[2] = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      check($sformatf("t3_both_e%0d", e), out_c, ((e >= 3 && e <= 5) || (e >= 13 && e <= 15)) ? 4'b0100 : 4'b0000);
      if (e == 10) in[2] = 1'b0;
    end
    mode = 8'b0011_0000;
    in[2] = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      check($sformatf("t3_off_e%0d", e), {miss_c, out_c}, 0);
      if (e == 10) in[2] = 1'b0;
    end

    // second edge during pulse: miss versus retrigger
    do_reset();
    in[3] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check($sformatf("t4_out_nort_e%0d", e), out_d, (e >= 3 && e <= 6) ? 4'b1000 : 4'b0000);
      check($sformatf("t4_out_rt_e%0d", e), out_e, (e >= 3 && e <= 9) ? 4'b1000 : 4'b0000);
      check($sformatf("t4_miss_nort_e%0d", e), miss_d, (e >= 6 && e <= 12) ? 4'b1000 : 4'b0000);
      check($sformatf("t4_miss_rt_e%0d", e), miss_e, 4'b0000);
      if (e == 2) in[3] = 1'b0;
      if (e == 3) in[3] = 1'b1;
      if (e == 12) miss_clr = 4'b1000;
      if (e == 13) miss_clr = 4'b0000;
    end

    // enable low during the edge suppresses the event
    do_reset();
    en = 1'b0;
    in[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("t5_en0_e%0d", e), out_d, 4'b0000);
      if (e == 8) en = 1'b1;
    end
    // enable dropped mid-pulse does not truncate it
    do_reset();
    in[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t5_drop_e%0d", e), out_d, (e >= 3 && e <= 6) ? 4'b0001 : 4'b0000);
      if (e == 3) en = 1'b0;
    end

    // reset mid-pulse, then input held high through reset
    do_reset();
    in[3] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 2) in[3] = 1'b0;
      if (e == 3) in[3] = 1'b1;
    end
    check("t6_pre_out", out_d, 4'b1000);
    check("t6_pre_miss", miss_d, 4'b1000);
    reset = 1'b1;
    tick();
    check("t6_rst_out", out_d, 4'b0000);
    check("t6_rst_miss", miss_d, 4'b0000);
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t6_held_e%0d", e), {miss_d, out_d}, (e >= 3 && e <= 6) ? 8'h08 : 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
